// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory fetch bus (req/gnt address phase, in-order rvalid data phase).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage; credit-limited imem fetch, in-flight PC queue and instr/PC buffer feeding IF/ID.
// Define FETCH_MISALIGN_CHK_EN to flag misaligned redirects (sticky misalign_o) and halt fetch until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic          ValidF,
  output logic [31:0]   InstrF,
  output logic [31:0]   PCF,
  output logic [31:0]   PCplus4F,
  output logic          misalign_o
);
  localparam int BW = $clog2(BUF_DEPTH);
  localparam int QW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_e;
  logic unused_tgt;
  assign unused_tgt = ^PCTargetE[1:0];
`endif
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, target;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   instr_q [BUF_DEPTH];
  logic [31:0]   instr_d [BUF_DEPTH];
  logic [31:0]   bpc_q [BUF_DEPTH];
  logic [31:0]   bpc_d [BUF_DEPTH];
  logic [BW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [BW:0]   count_q, count_d;
  logic [31:0]   ipc_q [MAX_OUTST];
  logic [31:0]   ipc_d [MAX_OUTST];
  logic [QW-1:0] ird_q, ird_d, iwr_q, iwr_d;
  logic          misalign_q, misalign_d;
  logic          grant, redirect, halt, halt_go, flush, push, pop;
  assign imem.imem_addr = pc_q;
  assign misalign_o     = misalign_q;
  always_comb begin
    ValidF   = count_q != '0;
    InstrF   = ValidF ? instr_q[rd_q] : NOP;
    PCF      = ValidF ? bpc_q[rd_q] : 32'h0;
    PCplus4F = ValidF ? bpc_q[rd_q] + 32'd4 : 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
    halt     = state_q == HALT;
    target   = PCTargetE;
    halt_go  = PCSrcE && !halt && PCTargetE[1:0] != 2'b00;
    state_d  = halt_go ? HALT : state_q == IDLE ? RUN : state_q;
`else
    halt     = 1'b0;
    target   = {PCTargetE[31:2], 2'b00};
    halt_go  = 1'b0;
    state_d  = state_q == IDLE ? RUN : state_q;
`endif
    redirect = PCSrcE && !halt;
    flush    = redirect || halt;
    // credit counts buffered, plus live in-flight entries, so a response always has a slot
    imem.imem_req = state_q == RUN && outst_q < OW'(MAX_OUTST) &&
                    32'(count_q) + 32'(outst_q) - 32'(drop_q) < 32'(BUF_DEPTH);
    grant      = imem.imem_req && imem.imem_gnt;
    push       = imem.imem_rvalid && drop_q == '0 && !flush;
    pop        = ValidF && !StallF && !flush;
    misalign_d = misalign_q || halt_go;
    pc_d       = redirect ? target : grant ? pc_q + 32'd4 : pc_q;
    outst_d    = outst_q + OW'(grant) - OW'(imem.imem_rvalid);
    drop_d     = redirect ? outst_d : (imem.imem_rvalid && drop_q != '0) ? drop_q - OW'(1) : drop_q;
    count_d    = flush ? '0 : count_q + (BW+1)'(push) - (BW+1)'(pop);
    rd_d       = flush ? '0 : rd_q + BW'(pop);
    wr_d       = flush ? '0 : wr_q + BW'(push);
    instr_d    = instr_q;
    bpc_d      = bpc_q;
    if (push) begin
      instr_d[wr_q] = imem.imem_rdata;
      bpc_d[wr_q]   = ipc_q[ird_q];
    end
    ipc_d = ipc_q;
    if (grant)
      ipc_d[iwr_q] = pc_q;
    iwr_d = grant ? (iwr_q == QW'(MAX_OUTST - 1) ? '0 : iwr_q + QW'(1)) : iwr_q;
    ird_d = imem.imem_rvalid ? (ird_q == QW'(MAX_OUTST - 1) ? '0 : ird_q + QW'(1)) : ird_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      ird_q      <= '0;
      iwr_q      <= '0;
      misalign_q <= 1'b0;
      instr_q    <= '{default: '0};
      bpc_q      <= '{default: '0};
      ipc_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ird_q      <= ird_d;
      iwr_q      <= iwr_d;
      misalign_q <= misalign_d;
      instr_q    <= instr_d;
      bpc_q      <= bpc_d;
      ipc_q      <= ipc_d;
    end
endmodule
